ldpc_mem_arb: RTL and testbench
===============================

# ldpc_mem_arb

LLR memory arbiter for the LDPC decoder. It shares one single-port Lq/Lr RAM between four requesters: the input loader (frame write during data-in), the decoder write path (VNU write-back), the decoder read path (CNU fetch) and the output unloader (hard-decision read during data-out). Fixed priority with starvation promotion; one RAM access per cycle; read data is returned with a per-requester valid strobe.

## Interface
- AW, 13, RAM address width (covers 6912-entry frame)
- DW, 48, RAM data width
- STARVE_MAX, 8, wait cycles before a blocked requester is promoted (1..15)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_req / in_addr / in_wdata  in  1 / AW / DW  input-loader write request
- in_gnt  out  1  input-loader grant
- dwr_req / dwr_addr / dwr_wdata  in  1 / AW / DW  decoder write request
- dwr_gnt  out  1  decoder write grant
- drd_req / drd_addr  in  1 / AW  decoder read request
- drd_gnt / drd_vld  out  1 / 1  decoder read grant / read data valid
- ord_req / ord_addr  in  1 / AW  output-unloader read request
- ord_gnt / ord_vld  out  1 / 1  output read grant / read data valid
- rd_data  out  DW  shared read data, qualified by drd_vld or ord_vld
- mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / AW / DW  RAM command, registered
- mem_rdata  in  DW  RAM read data, one cycle after mem_en
- stat_conflict  out  16  conflict counter (see Configuration)
- stat_clr  in  1  clears stat_conflict

## Operation
- Requests are level. A requester holds req, addr and wdata stable until it sees its gnt. gnt is combinational in the same cycle as the winning req. The requester may present its next request in the following cycle.
- Exactly one gnt is high per cycle, and only when at least one req is high.
- Base priority: in > dwr > drd > ord. in_req always wins. The loader is rate-guaranteed and is never stalled.
- Wait counters (4-bit) exist for dwr, drd and ord:
  - increment each cycle req=1 and gnt=0;
  - clear on gnt or req=0;
  - saturate at STARVE_MAX.
- A requester whose counter equals STARVE_MAX is starved. Starved requesters outrank non-starved dwr/drd/ord but never outrank in. Ties among starved requesters resolve by base priority.
- On a grant the command registers load: mem_en=1, mem_we=1 for in/dwr and 0 for drd/ord, plus the winner's addr and wdata. With no grant, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold.
- A read tag (2 bits, registered with the command) steers the return. rd_data is a register of mem_rdata. drd_vld/ord_vld assert for one cycle with rd_data.
- Read and write to the same address in consecutive cycles are allowed; the RAM's own ordering applies and no forwarding is done.

## Timing
- Cycle t: req sampled, gnt high.
- t+1: mem_* drive the RAM.
- t+2: mem_rdata valid.
- t+3: rd_data and the vld strobe valid.
- Read latency from gnt to vld is 3 cycles, with full throughput (one grant per cycle).
- Reset values: all gnt=0 (forced low while reset=1 regardless of req), mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_data=0, drd_vld=0, ord_vld=0, wait counters=0, read tag=idle, stat_conflict=0.
- Reset mid-operation: reads in flight are discarded and no vld is produced for them. The first grant is possible in the first cycle with reset=0.
- Simultaneous grant and counter saturation: the grant wins and the counter clears.

## Configuration
- LDPC_ARB_STAT_EN defined:
  - stat_conflict counts cycles with two or more req high;
  - saturates at 0xFFFF;
  - stat_clr=1 sets it to 0 in the next cycle, and clear has priority over count.
- LDPC_ARB_STAT_EN undefined: stat_conflict is tied to 0, stat_clr is ignored, and the counter logic is absent.

## Test plan
- Single read: drd_req=1, drd_addr=0x005 (RAM preloaded 0x005=0xA5) → drd_gnt at t; mem_en=1, mem_we=0, mem_addr=0x005 at t+1; drd_vld=1 with rd_data=0xA5 at t+3; ord_vld stays 0.
- Priority: in, dwr, drd and ord all requesting in one cycle → only in_gnt.
- Starvation:
  - dwr_req held high every cycle;
  - ord_req held from cycle 0;
  - expected: dwr granted cycles 0–7, ord_gnt at cycle 8 (STARVE_MAX=8), then dwr resumes.
- in never stalled: in_req continuous for 100 cycles while ord starved → in_gnt every cycle, ord_gnt=0.
- Stats (macro defined): 20 cycles with in_req=dwr_req=1 → stat_conflict=20; stat_clr pulse → 0 next cycle. Macro undefined: stat_conflict=0 throughout.
- Reset mid-read: assert reset at t+1 of a drd grant → no drd_vld, all outputs at reset values.

Source files
------------

// File: rtl/ldpc_mem_arb.sv
// LLR RAM arbiter: four requesters share one single-port RAM, fixed priority with starvation promotion.
// Optional conflict statistics counter enabled by defining LDPC_ARB_STAT_EN.
module ldpc_mem_arb #(
    parameter int AW         = 13,
    parameter int DW         = 48,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_req,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_wdata,
    output logic          in_gnt,
    input  logic          dwr_req,
    input  logic [AW-1:0] dwr_addr,
    input  logic [DW-1:0] dwr_wdata,
    output logic          dwr_gnt,
    input  logic          drd_req,
    input  logic [AW-1:0] drd_addr,
    output logic          drd_gnt,
    output logic          drd_vld,
    input  logic          ord_req,
    input  logic [AW-1:0] ord_addr,
    output logic          ord_gnt,
    output logic          ord_vld,
    output logic [DW-1:0] rd_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stat_conflict,
    input  logic          stat_clr
);

    typedef enum logic [1:0] {
        TAG_IDLE = 2'd0,
        TAG_DRD  = 2'd1,
        TAG_ORD  = 2'd2
    } rd_tag_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] wait_dwr, wait_drd, wait_ord;
    logic       starve_dwr, starve_drd, starve_ord;
    rd_tag_t    tag_cmd, tag_ram;

    assign starve_dwr = dwr_req && (wait_dwr == STARVE_LIM);
    assign starve_drd = drd_req && (wait_drd == STARVE_LIM);
    assign starve_ord = ord_req && (wait_ord == STARVE_LIM);

    // The loader always wins; starved requesters beat non-starved ones, ties by base order.
    always_comb begin
        in_gnt  = 1'b0;
        dwr_gnt = 1'b0;
        drd_gnt = 1'b0;
        ord_gnt = 1'b0;
        if (!reset) begin
            if (in_req)          in_gnt  = 1'b1;
            else if (starve_dwr) dwr_gnt = 1'b1;
            else if (starve_drd) drd_gnt = 1'b1;
            else if (starve_ord) ord_gnt = 1'b1;
            else if (dwr_req)    dwr_gnt = 1'b1;
            else if (drd_req)    drd_gnt = 1'b1;
            else if (ord_req)    ord_gnt = 1'b1;
        end
    end

    function automatic logic [3:0] next_wait(input logic req, input logic gnt,
                                             input logic [3:0] cnt);
        if (gnt || !req)         return 4'd0;
        else if (cnt == STARVE_LIM) return cnt;
        else                     return cnt + 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_dwr <= 4'd0;
            wait_drd <= 4'd0;
            wait_ord <= 4'd0;
        end else begin
            wait_dwr <= next_wait(dwr_req, dwr_gnt, wait_dwr);
            wait_drd <= next_wait(drd_req, drd_gnt, wait_drd);
            wait_ord <= next_wait(ord_req, ord_gnt, wait_ord);
        end
    end

    // Address and write data hold when idle; reads leave the write-data register untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tag_cmd   <= TAG_IDLE;
        end else begin
            mem_en  <= in_gnt | dwr_gnt | drd_gnt | ord_gnt;
            mem_we  <= in_gnt | dwr_gnt;
            tag_cmd <= drd_gnt ? TAG_DRD : (ord_gnt ? TAG_ORD : TAG_IDLE);
            if (in_gnt) begin
                mem_addr  <= in_addr;
                mem_wdata <= in_wdata;
            end else if (dwr_gnt) begin
                mem_addr  <= dwr_addr;
                mem_wdata <= dwr_wdata;
            end else if (drd_gnt) begin
                mem_addr  <= drd_addr;
            end else if (ord_gnt) begin
                mem_addr  <= ord_addr;
            end
        end
    end

    // The tag follows the RAM's one-cycle latency, then qualifies the registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_ram <= TAG_IDLE;
            rd_data <= '0;
            drd_vld <= 1'b0;
            ord_vld <= 1'b0;
        end else begin
            tag_ram <= tag_cmd;
            rd_data <= mem_rdata;
            drd_vld <= (tag_ram == TAG_DRD);
            ord_vld <= (tag_ram == TAG_ORD);
        end
    end

`ifdef LDPC_ARB_STAT_EN
    logic [2:0] req_count;
    assign req_count = 3'(in_req) + 3'(dwr_req) + 3'(drd_req) + 3'(ord_req);

    always_ff @(posedge clk) begin
        if (reset || stat_clr)
            stat_conflict <= 16'd0;
        else if (req_count >= 3'd2 && stat_conflict != 16'hFFFF)
            stat_conflict <= stat_conflict + 16'd1;
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_conflict   = 16'd0;
`endif

endmodule

// File: tb/tb_ldpc_mem_arb.sv
// Directed self-checking bench for ldpc_mem_arb with a behavioural single-port RAM.
module tb_ldpc_mem_arb;

    localparam int AW = 13;
    localparam int DW = 48;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_req, dwr_req, drd_req, ord_req;
    logic [AW-1:0] in_addr, dwr_addr, drd_addr, ord_addr;
    logic [DW-1:0] in_wdata, dwr_wdata;
    logic          in_gnt, dwr_gnt, drd_gnt, ord_gnt;
    logic          drd_vld, ord_vld;
    logic [DW-1:0] rd_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   stat_conflict;
    logic          stat_clr;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    ldpc_mem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .in_req(in_req), .in_addr(in_addr), .in_wdata(in_wdata), .in_gnt(in_gnt),
        .dwr_req(dwr_req), .dwr_addr(dwr_addr), .dwr_wdata(dwr_wdata), .dwr_gnt(dwr_gnt),
        .drd_req(drd_req), .drd_addr(drd_addr), .drd_gnt(drd_gnt), .drd_vld(drd_vld),
        .ord_req(ord_req), .ord_addr(ord_addr), .ord_gnt(ord_gnt), .ord_vld(ord_vld),
        .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stat_conflict(stat_conflict), .stat_clr(stat_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs change 1 time unit after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkGrants(input string tag, input logic [3:0] exp);
        @(negedge clk);
        checkOutput(tag, {60'd0, in_gnt, dwr_gnt, drd_gnt, ord_gnt}, {60'd0, exp});
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        ram[13'h005] = 48'hA5;
        mem_rdata = '0;
        reset = 1'b1; stat_clr = 1'b0;
        in_req = 1'b1; dwr_req = 1'b1; drd_req = 1'b1; ord_req = 1'b1;
        in_addr = '0; dwr_addr = '0; drd_addr = '0; ord_addr = '0;
        in_wdata = '0; dwr_wdata = '0;

        // Reset values, grants forced low although every requester is asserting
        applyStimulus();
        applyStimulus();
        checkGrants("reset_gnt", 4'b0000);
        checkOutput("reset_mem_en", 64'(mem_en), 64'd0);
        checkOutput("reset_mem_we", 64'(mem_we), 64'd0);
        checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("reset_mem_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("reset_rd_data", 64'(rd_data), 64'd0);
        checkOutput("reset_vld", {62'd0, drd_vld, ord_vld}, 64'd0);
        checkOutput("reset_stat", 64'(stat_conflict), 64'd0);

        // Single decoder read of 0x005
        applyStimulus();
        reset = 1'b0; in_req = 0; dwr_req = 0; ord_req = 0;
        drd_req = 1'b1; drd_addr = 13'h005;
        checkGrants("rd_gnt_t", 4'b0010);
        applyStimulus();
        drd_req = 1'b0;
        @(negedge clk);
        checkOutput("rd_mem_en", 64'(mem_en), 64'd1);
        checkOutput("rd_mem_we", 64'(mem_we), 64'd0);
        checkOutput("rd_mem_addr", 64'(mem_addr), 64'h005);
        applyStimulus();
        @(negedge clk);
        checkOutput("rd_vld_t2", {62'd0, drd_vld, ord_vld}, 64'd0);
        applyStimulus();
        @(negedge clk);
        checkOutput("rd_drd_vld_t3", 64'(drd_vld), 64'd1);
        checkOutput("rd_ord_vld_t3", 64'(ord_vld), 64'd0);
        checkOutput("rd_data_t3", 64'(rd_data), 64'hA5);
        applyStimulus();
        @(negedge clk);
        checkOutput("rd_vld_t4", {62'd0, drd_vld, ord_vld}, 64'd0);

        // Loader write then output-unloader read back
        in_req = 1'b1; in_addr = 13'h010; in_wdata = 48'h1234_5678_9ABC;
        checkGrants("wr_gnt", 4'b1000);
        applyStimulus();
        in_req = 1'b0;
        @(negedge clk);
        checkOutput("wr_mem_we", 64'(mem_we), 64'd1);
        checkOutput("wr_mem_wdata", 64'(mem_wdata), 64'h1234_5678_9ABC);
        checkOutput("wr_mem_addr", 64'(mem_addr), 64'h010);
        applyStimulus();
        ord_req = 1'b1; ord_addr = 13'h010;
        checkGrants("ord_gnt", 4'b0001);
        applyStimulus();
        ord_req = 1'b0;
        applyStimulus();
        applyStimulus();
        @(negedge clk);
        checkOutput("ord_vld", 64'(ord_vld), 64'd1);
        checkOutput("ord_drd_vld", 64'(drd_vld), 64'd0);
        checkOutput("ord_rd_data", 64'(rd_data), 64'h1234_5678_9ABC);

        // All four requesting: only the loader wins
        applyStimulus();
        in_req = 1; dwr_req = 1; drd_req = 1; ord_req = 1;
        in_addr = 13'h020; in_wdata = 48'h77;
        checkGrants("prio_all", 4'b1000);
        applyStimulus();
        in_req = 0; dwr_req = 0; drd_req = 0; ord_req = 0;
        checkGrants("idle_gnt", 4'b0000);
        checkOutput("prio_mem_addr", 64'(mem_addr), 64'h020);
        applyStimulus();
        @(negedge clk);
        checkOutput("idle_mem_en", 64'(mem_en), 64'd0);
        checkOutput("idle_mem_we", 64'(mem_we), 64'd0);
        checkOutput("idle_addr_hold", 64'(mem_addr), 64'h020);

        // Starvation: dwr granted cycles 0-7, ord promoted at cycle 8, dwr resumes
        applyStimulus();
        dwr_req = 1'b1; ord_req = 1'b1; dwr_addr = 13'h030; ord_addr = 13'h040;
        for (int c = 0; c <= 10; c++) begin
            if (c == 9) ord_req = 1'b0;
            checkGrants($sformatf("starve_c%0d", c), (c == 8) ? 4'b0001 : 4'b0100);
            applyStimulus();
        end
        dwr_req = 1'b0;
        applyStimulus();
        applyStimulus();
        applyStimulus();

        // Loader continuous for 100 cycles while ord waits, then ord goes first once starved
        in_req = 1'b1; ord_req = 1'b1;
        for (int c = 0; c < 100; c++) begin
            checkGrants($sformatf("in_stream_c%0d", c), 4'b1000);
            applyStimulus();
        end
        in_req = 1'b0;
        checkGrants("ord_after_stream", 4'b0001);
        applyStimulus();
        ord_req = 1'b0;
        applyStimulus();

        // Conflict statistics
        stat_clr = 1'b1;
        applyStimulus();
        stat_clr = 1'b0; in_req = 1'b1; dwr_req = 1'b1;
        @(negedge clk);
        checkOutput("stat_after_clr", 64'(stat_conflict), 64'd0);
        for (int c = 0; c < 19; c++) applyStimulus();
        applyStimulus();
        in_req = 1'b0; dwr_req = 1'b0;
        @(negedge clk);
`ifdef LDPC_ARB_STAT_EN
        checkOutput("stat_20", 64'(stat_conflict), 64'd20);
`else
        checkOutput("stat_20", 64'(stat_conflict), 64'd0);
`endif
        applyStimulus();
        stat_clr = 1'b1;
        applyStimulus();
        stat_clr = 1'b0;
        @(negedge clk);
        checkOutput("stat_cleared", 64'(stat_conflict), 64'd0);
        applyStimulus();
        applyStimulus();
        applyStimulus();

        // Reset one cycle after a decoder read grant aborts it
        drd_req = 1'b1; drd_addr = 13'h005;
        checkGrants("rst_rd_gnt", 4'b0010);
        applyStimulus();
        reset = 1'b1;
        checkGrants("rst_forced_gnt", 4'b0000);
        applyStimulus();
        reset = 1'b0;
        checkGrants("rst_first_gnt", 4'b0010);
        checkOutput("rst_mem_en", 64'(mem_en), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("rst_rd_data", 64'(rd_data), 64'd0);
        checkOutput("rst_vld_t2", {62'd0, drd_vld, ord_vld}, 64'd0);
        applyStimulus();
        drd_req = 1'b0;
        @(negedge clk);
        checkOutput("rst_vld_t3", {62'd0, drd_vld, ord_vld}, 64'd0);
        applyStimulus();
        @(negedge clk);
        checkOutput("rst_vld_t4", {62'd0, drd_vld, ord_vld}, 64'd0);
        applyStimulus();
        @(negedge clk);
        checkOutput("rst_new_vld", 64'(drd_vld), 64'd1);
        checkOutput("rst_new_data", 64'(rd_data), 64'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
